// File: rtl/slot_scheduler.sv
// Round-robin time-slot sequencer: walks the enabled slots of a frame, holding each
// for a programmable dwell, and drives 4'hF whenever no slot is active.
module slot_scheduler #(
  parameter int NUM_SLOTS = 9,
  parameter int DWELL_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 advance,
  input  logic                 hold,
  output logic [3:0]           current_slot,
  output logic                 slot_valid,
  output logic                 slot_start,
  output logic                 frame_wrap
);

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  localparam logic [3:0] NO_SLOT = 4'hF;

  function automatic logic [3:0] lowest_set(input logic [NUM_SLOTS-1:0] m);
    logic [3:0] idx;
    idx = NO_SLOT;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] lowest_above(input logic [NUM_SLOTS-1:0] m,
                                              input logic [3:0]           cur);
    logic [3:0] idx;
    idx = NO_SLOT;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [3:0]         r_slot;
  logic               r_valid;
  logic               r_start;
  logic               r_wrap;

  state_t             w_state_n;
  logic [DWELL_W-1:0] w_cnt_n;
  logic [3:0]         w_slot_n;
  logic               w_valid_n;
  logic               w_start_n;
  logic               w_wrap_n;

  logic [3:0]         w_first;
  logic [3:0]         w_above;
  logic [3:0]         w_next;
  logic               w_any;
  logic               w_end;
  logic [DWELL_W-1:0] w_load;

  assign w_first = lowest_set(slot_mask);
  assign w_above = lowest_above(slot_mask, r_slot);
  assign w_next  = (w_above != NO_SLOT) ? w_above : w_first;
  assign w_any   = |slot_mask;
  // A zero dwell behaves like one cycle, so the reload value saturates at zero.
  assign w_load  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign w_end   = advance || (!hold && (r_cnt == '0));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_slot_n  = r_slot;
    w_valid_n = r_valid;
    w_start_n = 1'b0;
    w_wrap_n  = 1'b0;
    case (r_state)
      IDLE: begin
        w_slot_n  = NO_SLOT;
        w_valid_n = 1'b0;
        if (enable && w_any) begin
          w_state_n = DWELL;
          w_slot_n  = w_first;
          w_valid_n = 1'b1;
          w_start_n = 1'b1;
          w_cnt_n   = w_load;
        end
      end
      DWELL: begin
        if (!enable) begin
          w_state_n = IDLE;
          w_slot_n  = NO_SLOT;
          w_valid_n = 1'b0;
        end else if (w_end) begin
          // The mask seen on the deciding cycle picks the successor, or idles the sequencer.
          if (!w_any) begin
            w_state_n = IDLE;
            w_slot_n  = NO_SLOT;
            w_valid_n = 1'b0;
          end else begin
            w_slot_n  = w_next;
            w_start_n = 1'b1;
            w_wrap_n  = (w_next <= r_slot);
            w_cnt_n   = w_load;
          end
        end else if (!hold) begin
          w_cnt_n = r_cnt - DWELL_W'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_slot_n  = NO_SLOT;
        w_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_slot  <= NO_SLOT;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_slot  <= w_slot_n;
      r_valid <= w_valid_n;
      r_start <= w_start_n;
      r_wrap  <= w_wrap_n;
    end
  end

  assign current_slot = r_slot;
  assign slot_valid   = r_valid;
  assign slot_start   = r_start;
  assign frame_wrap   = r_wrap;

endmodule

// File: tb/tb_slot_scheduler.sv
// Directed bench for slot_scheduler: expected per-cycle outputs are queued as each
// scenario is set up and checked against the DUT one cycle at a time.
module tb_slot_scheduler;

  localparam int NS = 9;
  localparam int DW = 8;

  typedef struct packed {
    logic [3:0] slot;
    logic       valid;
    logic       start;
    logic       wrap;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NS-1:0] slot_mask;
  logic [DW-1:0] dwell;
  logic          advance;
  logic          hold;
  logic [3:0]    current_slot;
  logic          slot_valid;
  logic          slot_start;
  logic          frame_wrap;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string phase    = "reset";
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  slot_scheduler #(.NUM_SLOTS(NS), .DWELL_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .slot_mask    (slot_mask),
    .dwell        (dwell),
    .advance      (advance),
    .hold         (hold),
    .current_slot (current_slot),
    .slot_valid   (slot_valid),
    .slot_start   (slot_start),
    .frame_wrap   (frame_wrap)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".slot"},  current_slot,         e.slot);
    chk({tag, ".valid"}, {3'b000, slot_valid}, {3'b000, e.valid});
    chk({tag, ".start"}, {3'b000, slot_start}, {3'b000, e.start});
    chk({tag, ".wrap"},  {3'b000, frame_wrap}, {3'b000, e.wrap});
  endtask

  task automatic push_e(input logic [3:0] s, input logic v, input logic st, input logic w);
    exp_t e;
    e.slot  = s;
    e.valid = v;
    e.start = st;
    e.wrap  = w;
    exp_q.push_back(e);
  endtask

  task automatic push_slot(input logic [3:0] s, input logic w, input int n);
    for (int i = 0; i < n; i++) push_e(s, 1'b1, (i == 0), (i == 0) ? w : 1'b0);
  endtask

  task automatic push_cont(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) push_e(s, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_e(4'hF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL %s@%0d.queue: observed empty expectation queue, expected an entry", phase, cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_outputs($sformatf("%s@%0d", phase, cyc), e);
      end
    end
  endtask

  initial begin
    exp_t rst_e;
    rst_e = '{slot: 4'hF, valid: 1'b0, start: 1'b0, wrap: 1'b0};

    reset     = 1'b1;
    enable    = 1'b0;
    slot_mask = '0;
    dwell     = '0;
    advance   = 1'b0;
    hold      = 1'b0;
    #1;
    chk_outputs("reset_state", rst_e);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_idle(2);
    step(2);

    phase     = "full_mask";
    slot_mask = 9'h1FF;
    dwell     = 8'd3;
    enable    = 1'b1;
    for (int s = 0; s < 9; s++) push_slot(4'(s), 1'b0, 3);
    push_slot(4'd0, 1'b1, 1);
    step(28);
    enable = 1'b0;
    push_idle(2);
    step(2);

    phase     = "sparse_mask";
    slot_mask = 9'b100010010;
    dwell     = 8'd2;
    enable    = 1'b1;
    push_slot(4'd1, 1'b0, 2);
    push_slot(4'd4, 1'b0, 2);
    push_slot(4'd8, 1'b0, 2);
    push_slot(4'd1, 1'b1, 2);
    push_slot(4'd4, 1'b0, 2);
    push_slot(4'd8, 1'b0, 2);
    push_slot(4'd1, 1'b1, 1);
    step(13);
    enable = 1'b0;
    push_idle(1);
    step(1);

    phase     = "advance";
    slot_mask = 9'h1FF;
    dwell     = 8'd5;
    enable    = 1'b1;
    push_slot(4'd0, 1'b0, 2);
    step(2);
    advance = 1'b1;
    push_slot(4'd1, 1'b0, 1);
    step(1);
    hold = 1'b1;
    push_slot(4'd2, 1'b0, 1);
    step(1);
    advance = 1'b0;
    push_cont(4'd2, 3);
    step(3);
    hold = 1'b0;
    push_cont(4'd2, 4);
    push_slot(4'd3, 1'b0, 1);
    step(5);
    enable = 1'b0;
    push_idle(1);
    step(1);

    phase  = "hold_dwell0";
    dwell  = 8'd4;
    enable = 1'b1;
    push_slot(4'd0, 1'b0, 2);
    step(2);
    hold = 1'b1;
    push_cont(4'd0, 3);
    step(3);
    hold = 1'b0;
    push_cont(4'd0, 2);
    push_slot(4'd1, 1'b0, 1);
    step(3);
    dwell = 8'd0;
    push_cont(4'd1, 3);
    push_slot(4'd2, 1'b0, 1);
    push_slot(4'd3, 1'b0, 1);
    push_slot(4'd4, 1'b0, 1);
    step(6);
    enable = 1'b0;
    push_idle(1);
    step(1);

    phase  = "mask_clear";
    dwell  = 8'd3;
    enable = 1'b1;
    push_slot(4'd0, 1'b0, 3);
    push_slot(4'd1, 1'b0, 3);
    push_slot(4'd2, 1'b0, 1);
    step(7);
    slot_mask = '0;
    push_cont(4'd2, 2);
    push_idle(2);
    step(4);
    phase   = "idle_advance";
    advance = 1'b1;
    push_idle(1);
    step(1);
    advance = 1'b0;
    enable  = 1'b0;

    phase     = "single_slot";
    slot_mask = 9'h020;
    dwell     = 8'd2;
    enable    = 1'b1;
    push_slot(4'd5, 1'b0, 2);
    push_slot(4'd5, 1'b1, 2);
    push_slot(4'd5, 1'b1, 2);
    push_slot(4'd5, 1'b1, 1);
    step(7);
    phase  = "enable_drop";
    enable = 1'b0;
    push_idle(1);
    step(1);

    phase     = "async_reset";
    slot_mask = 9'h1FF;
    dwell     = 8'd3;
    enable    = 1'b1;
    push_slot(4'd0, 1'b0, 2);
    step(2);
    #2;
    reset = 1'b1;
    #1;
    chk_outputs("async_reset_now", rst_e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_slot(4'd0, 1'b0, 1);
    step(1);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_scheduler.md
# slot_scheduler

Round-robin time-slot sequencer that produces the 4-bit `current_slot` index consumed by the slot decoder, which turns it into a 9-bit one-hot select. It steps through the enabled slots of a 9-slot frame, holds each slot for a programmable dwell time, skips masked-off slots, and supports early advance and hold. When idle it drives an out-of-range index (4'hF), so the downstream decoder outputs all zeros.

## Interface
- `NUM_SLOTS`, 9: slots per frame, legal 1..9; valid indices are 0..NUM_SLOTS-1.
- `DWELL_W`, 8: width of the dwell-time input.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: run request; low forces IDLE.
- `slot_mask` in NUM_SLOTS: bit i = 1 means slot i participates.
- `dwell` in DWELL_W: cycles each slot is held; 0 is treated as 1.
- `advance` in 1: single-cycle request to end the current slot early.
- `hold` in 1: freezes the dwell countdown.
- `current_slot` out 4: active slot index; 4'hF when not running.
- `slot_valid` out 1: high while `current_slot` is a valid index.
- `slot_start` out 1: one-cycle pulse on the first cycle of each slot.
- `frame_wrap` out 1: one-cycle pulse coincident with `slot_start` when the index wraps.

## Operation
- All outputs are registered.
- Reset values: `current_slot`=4'hF, `slot_valid`=0, `slot_start`=0, `frame_wrap`=0, state=IDLE, dwell counter=0.
- States: IDLE, DWELL.
- IDLE → DWELL when `enable`=1 and `slot_mask`≠0.
  - Entered slot: lowest set bit of `slot_mask`.
  - `slot_start`=1, `frame_wrap`=0.
- DWELL → IDLE when `enable`=0. This has priority over every other event.
- Slot entry: dwell counter loads max(`dwell`,1)-1. `dwell` is sampled only at entry, so changes take effect from the next slot.
- Per cycle in DWELL, evaluated in order:
  - `advance`=1: end the slot this cycle, regardless of `hold` and the counter value.
  - Otherwise `hold`=1: counter frozen.
  - Otherwise, counter≠0: counter decrements.
  - Otherwise, counter==0: end the slot.
- Slot end selects the next slot: the lowest set mask bit strictly above the current index, else the lowest set bit overall (wrap).
  - The mask is the value present on the deciding cycle.
  - `frame_wrap`=1 when the new index ≤ the old index. This includes a single enabled slot re-entering itself.
  - If the mask is 0 on the deciding cycle, go to IDLE (`current_slot`=4'hF, no pulses).
- Mask changes mid-slot do not cut the current slot short, even if its own bit is cleared. They affect only the next selection.
- Mask bits at or above `NUM_SLOTS` do not exist; `current_slot` never exceeds NUM_SLOTS-1 while valid.
- `advance` while in IDLE is ignored.
- `slot_valid` is 1 exactly when state=DWELL.

## Timing
- `enable` rises, sampled at edge N, with a nonzero mask: at N+1 `current_slot` = first slot, `slot_valid`=1, `slot_start`=1. This is 1-cycle latency.
- With no `hold` and no `advance`, each slot occupies exactly D = max(`dwell`,1) cycles. The next slot appears at N+1+D.
- `advance` sampled at edge M: the new slot is visible at M+1.
- `enable` falls, sampled at edge M: at M+1 `current_slot`=4'hF and `slot_valid`=0. No `slot_start` pulse.
- `hold` extends the current slot by the number of cycles it is high, provided the counter has not yet ended the slot.
- `slot_start` and `frame_wrap` are high for exactly one cycle per event. Back-to-back slots with D=1 give `slot_start` high every cycle.
- Asynchronous `reset` mid-slot: outputs take their reset values immediately. Operation resumes from IDLE one cycle after `reset` deasserts, if `enable`=1.

## Test plan
- Reset, then `enable`=1, mask=9'h1FF, `dwell`=3 → `current_slot` runs 0..8, each held 3 cycles; `frame_wrap` pulses on re-entry to 0 at cycle 28 after enable.
- mask=9'b100010010, `dwell`=2 → sequence 1,4,8,1,…; `frame_wrap` with each 8→1 transition; slots 0,2,3,5,6,7 never appear.
- `dwell`=5, `advance` pulsed on the 2nd cycle of slot 0 → slot 1 starts on the next cycle. `advance` together with `hold`=1 also advances.
- `dwell`=4, `hold` high for 3 cycles mid-slot → the slot lasts 7 cycles. `dwell`=0 → each slot lasts 1 cycle.
- Mask cleared to 0 during slot 2 → slot 2 completes its dwell, then `current_slot`=4'hF and `slot_valid`=0. Single-bit mask 9'h020 → slot 5 repeats with `frame_wrap` on every `slot_start` after the first.
- `enable` dropped mid-slot → IDLE on the next cycle. `reset` asserted mid-slot asynchronously → 4'hF without waiting for a clock edge.
